// File: rtl/shooter_pkg.sv
// Shared playfield constants, coordinate type and shot FSM states for the
// player's bullet pool.
package shooter_pkg;

    typedef logic [9:0] coord_t;

    localparam int unsigned TOP_Y   = 71;
    localparam int unsigned X_MIN   = 199;
    localparam int unsigned X_MAX   = 489;
    localparam int unsigned Y_MIN   = 90;
    localparam int unsigned Y_MAX   = 453;
    localparam int unsigned NOSE_DY = 19;

    // Horizontal offset of each bullet from the plane centre in twin-shot mode
    localparam int unsigned TWIN_DX = 8;

    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_COOLDOWN = 2'd1,
        ST_HALT     = 2'd2
    } shot_state_t;

endpackage

// File: rtl/bullet_scheduler_if.sv
// Bus between the plane/collision logic (master) and the bullet scheduler
// (slave). Bullet coordinates are packed 10 bits per slot, slot 0 lowest.
interface bullet_scheduler_if #(
    parameter int unsigned NSLOT = 8
) ();
    import shooter_pkg::*;

    logic                  gameover;
    logic                  fire;
    coord_t                planex;
    coord_t                planey;
    logic [NSLOT-1:0]      hit;
    logic [NSLOT-1:0]      bullet_valid;
    logic [NSLOT*10-1:0]   bullet_x;
    logic [NSLOT*10-1:0]   bullet_y;
    logic                  fired;

    modport master (
        output gameover, fire, planex, planey, hit,
        input  bullet_valid, bullet_x, bullet_y, fired
    );

    modport slave (
        input  gameover, fire, planex, planey, hit,
        output bullet_valid, bullet_x, bullet_y, fired
    );

endinterface

// File: rtl/bullet_slot.sv
// One bullet slot: loads a spawn position, then climbs SPEED pixels per tick
// until it is hit, reaches the playfield top, or the pool is cleared.
// Position is kept after the slot retires.
module bullet_slot
    import shooter_pkg::*;
#(
    parameter int unsigned SPEED = 3
) (
    input  logic   clk_10ms,
    input  logic   rst_n,
    input  logic   spawn,
    input  coord_t spawn_x,
    input  coord_t spawn_y,
    input  logic   hit,
    input  logic   clear,
    output logic   valid,
    output coord_t x,
    output coord_t y
);

    // A bullet below this line retires instead of moving, so y never wraps
    localparam coord_t RETIRE_Y = coord_t'(TOP_Y + SPEED);
    localparam coord_t STEP     = coord_t'(SPEED);

    // Slot state: clear beats spawn beats hit beats retire beats move
    always_ff @(posedge clk_10ms or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            x     <= '0;
            y     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (spawn) begin
            valid <= 1'b1;
            x     <= spawn_x;
            y     <= spawn_y;
        end else if (valid) begin
            if (hit) begin
                valid <= 1'b0;
            end else if (y < RETIRE_Y) begin
                valid <= 1'b0;
            end else begin
                y <= y - STEP;
            end
        end
    end

endmodule

// File: rtl/bullet_scheduler.sv
// Player bullet pool: cooldown-throttled fire FSM, lowest-free-slot
// allocation and NSLOT bullet_slot instances.
// Optional build macro: BULLET_TWIN_SHOT_EN (two bullets per shot at
// planex-8 / planex+8 when two slots are free).
module bullet_scheduler
    import shooter_pkg::*;
#(
    parameter int unsigned NSLOT    = 8,
    parameter int unsigned COOLDOWN = 15,
    parameter int unsigned SPEED    = 3,
    parameter int unsigned NOSE_DY  = shooter_pkg::NOSE_DY
) (
    input  logic              clk_10ms,
    input  logic              rst_n,
    bullet_scheduler_if.slave bus
);

    localparam int unsigned IW = $clog2(NSLOT);
    localparam int unsigned CW = (COOLDOWN > 2) ? $clog2(COOLDOWN) : 1;

    shot_state_t      state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             fired_q, fired_n;
    logic             shoot;

    logic [NSLOT-1:0] valid;
    logic [NSLOT-1:0] spawn_vec;
    coord_t           spawn_x [NSLOT];
    coord_t           spawn_y;

    logic             any_free;
    logic [IW-1:0]    first_idx;
`ifdef BULLET_TWIN_SHOT_EN
    logic             second_free;
    logic [IW-1:0]    second_idx;
`endif

    assign spawn_y = bus.planey - coord_t'(NOSE_DY);

    // Lowest (and in twin mode second-lowest) free slot from registered valid
    always_comb begin
        any_free  = 1'b0;
        first_idx = '0;
`ifdef BULLET_TWIN_SHOT_EN
        second_free = 1'b0;
        second_idx  = '0;
`endif
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (!valid[i]) begin
                if (!any_free) begin
                    any_free  = 1'b1;
                    first_idx = IW'(i);
                end
`ifdef BULLET_TWIN_SHOT_EN
                else if (!second_free) begin
                    second_free = 1'b1;
                    second_idx  = IW'(i);
                end
`endif
            end
        end
    end

    // Fire FSM next state, cooldown count and shot decision
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fired_n = 1'b0;
        shoot   = 1'b0;
        if (bus.gameover) begin
            state_n = ST_HALT;
            cnt_n   = '0;
        end else begin
            unique case (state)
                ST_ARMED: begin
                    if (bus.fire && (bus.planex != '0) && any_free) begin
                        shoot   = 1'b1;
                        fired_n = 1'b1;
                        cnt_n   = CW'(COOLDOWN - 1);
                        state_n = ST_COOLDOWN;
                    end
                end
                ST_COOLDOWN: begin
                    if (cnt == '0) begin
                        state_n = ST_ARMED;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
                ST_HALT: begin
                    state_n = ST_ARMED;
                end
                default: begin
                    state_n = ST_ARMED;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Per-slot spawn enables and spawn x positions for this tick's shot
    always_comb begin
        spawn_vec = '0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            spawn_x[i] = bus.planex;
        end
        if (shoot) begin
`ifdef BULLET_TWIN_SHOT_EN
            if (second_free) begin
                spawn_vec[first_idx]  = 1'b1;
                spawn_vec[second_idx] = 1'b1;
                spawn_x[first_idx]    = bus.planex - coord_t'(TWIN_DX);
                spawn_x[second_idx]   = bus.planex + coord_t'(TWIN_DX);
            end else begin
                spawn_vec[first_idx]  = 1'b1;
            end
`else
            spawn_vec[first_idx] = 1'b1;
`endif
        end
    end

    // FSM state, cooldown counter and fired pulse registers
    always_ff @(posedge clk_10ms or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_ARMED;
            cnt     <= '0;
            fired_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            fired_q <= fired_n;
        end
    end

    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        bullet_slot #(
            .SPEED (SPEED)
        ) u_slot (
            .clk_10ms (clk_10ms),
            .rst_n    (rst_n),
            .spawn    (spawn_vec[g]),
            .spawn_x  (spawn_x[g]),
            .spawn_y  (spawn_y),
            .hit      (bus.hit[g]),
            .clear    (bus.gameover),
            .valid    (valid[g]),
            .x        (bus.bullet_x[10*g +: 10]),
            .y        (bus.bullet_y[10*g +: 10])
        );
    end

    assign bus.bullet_valid = valid;
    assign bus.fired        = fired_q;

endmodule

// File: doc/bullet_scheduler.md
Name: bullet_scheduler

Overview:
- Owns the player's bullet pool: NSLOT bullet slots shared by the fire button.
- Allocates a free slot on each fire, throttles firing with a cooldown FSM, and advances every live bullet upward once per 10 ms tick.
- Retires bullets at the playfield top or on a collision hit.
- Sits between the plane position logic (planex/planey) and the VGA renderer / collision checker.

Parameters:
- NSLOT, 8, number of bullet slots (2..16)
- COOLDOWN, 15, ticks spent in COOLDOWN after a shot; fire period while held is COOLDOWN+1 ticks
- SPEED, 3, pixels a bullet moves up per tick
- NOSE_DY, 19, offset from plane centre to nose; spawn y = planey - NOSE_DY
- TOP_Y, 71, playfield top edge in screen coordinates

Ports:
- clk_10ms  in  1  game tick clock, 100 Hz
- rst_n  in  1  asynchronous active-low reset
- gameover  in  1  level; freezes and clears the pool
- fire  in  1  level, fire button (debounced upstream)
- planex  in  10  plane centre x; 0 = plane dead
- planey  in  10  plane centre y
- hit  in  NSLOT  per-slot kill from the collision checker, sampled on the same edge
- bullet_valid  out  NSLOT  slot i live
- bullet_x  out  NSLOT*10  slot i x at bits [10i+9:10i]
- bullet_y  out  NSLOT*10  slot i y, same packing
- fired  out  1  one-tick pulse when a bullet spawns

Behaviour:
- Reset (async, rst_n=0):
  - bullet_valid=0, all bullet_x/bullet_y=0, fired=0.
  - FSM=ARMED, cooldown counter=0.
- FSM states:
  - ARMED: if fire && planex!=0 && !gameover && any free slot, spawn into the lowest-index free slot, pulse fired, load cnt=COOLDOWN-1, go to COOLDOWN. If fire is high but no slot is free, stay ARMED with no spawn; the press is not queued.
  - COOLDOWN: cnt decrements each tick; at cnt==0 go to ARMED. COOLDOWN=0 is illegal.
  - HALT: entered from any state when gameover=1; all valid bits cleared and cnt=0. Leave for ARMED on the first tick with gameover=0. Fire is ignored on that exit tick.
- Spawn:
  - x=planex, y=planey-NOSE_DY.
  - The new slot becomes valid next edge at the spawn position; it does not move during its spawn tick.
- Move, per live slot per tick:
  - If hit[i]: valid<=0; x/y hold their last value.
  - Else if y < TOP_Y+SPEED: valid<=0 (retire at top).
  - Else y<=y-SPEED.
  - Hit takes priority over move and retire.
- Free-slot rule: a slot freed this tick (by hit or retire) is not allocatable until the next tick. Allocation uses the registered valid vector.
- hit[i] on an invalid slot is ignored.
- Arithmetic is 10-bit unsigned. The retire compare prevents underflow, so y never wraps.
- Latency:
  - fire high in ARMED → bullet_valid visible 1 tick later, same edge as fired.
  - Continuous fire yields one spawn every COOLDOWN+1 ticks.

Optional Feature:
- Macro: BULLET_TWIN_SHOT_EN.
- Defined: each shot spawns two bullets at planex-8 and planex+8 into the two lowest free slots; fired pulses once. If only one slot is free, a single centre bullet at planex spawns.
- Undefined: single centre bullet only, and the second-slot search logic is absent.

Decomposition:
- Package shooter_pkg holds:
  - playfield constants TOP_Y=71, X_MIN=199, X_MAX=489, Y_MIN=90, Y_MAX=453, NOSE_DY
  - the FSM state enum (ARMED/COOLDOWN/HALT)
  - the 10-bit coordinate typedef
- Sub-module bullet_slot, instanced NSLOT times:
  - inputs: spawn enable, spawn x/y, hit, clear
  - outputs: valid, x, y
  - contains the move/retire logic.
- The top level holds the FSM, cooldown counter and lowest-free priority encoder.

Test Plan:
1. Reset, then planex=344, planey=413, fire pulse 1 tick → next tick fired=1, valid[0]=1, x0=344, y0=394; the following tick y0=391.
2. fire held high for 40 ticks, COOLDOWN=15 → spawns at ticks 0, 16, 32 into slots 0, 1, 2; fired high exactly 3 times.
3. Slot 0 at y=73 (73 < 71+3) → retires next tick, valid[0]=0. A slot at y=74 moves to 71 and stays valid.
4. All 8 slots valid, fire in ARMED → no spawn, fired=0, FSM stays ARMED. hit[3]=1 that tick → valid[3]=0 next tick; fire the tick after lands in slot 3.
5. gameover=1 in COOLDOWN with 5 live bullets → next tick valid=0, FSM=HALT, fire ignored. gameover=0 → ARMED one tick later, and fire then spawns into slot 0.
6. rst_n low mid-COOLDOWN, asynchronous, between edges → valid=0 and fired=0 immediately. planex=0 with fire=1 → no spawn.
